// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the reg_file_sb register file with issue scoreboard.
package reg_file_sb_pkg;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
  localparam int NRD_MAX       = 4;
  localparam int NWR_MAX       = 3;

  typedef logic [AW_DEFAULT-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_sb_popcount_busy.sv
// Population count of the scoreboard busy vector.
module popcount_busy #(
  parameter int NREGS = 32,
  parameter int CW    = $clog2(NREGS) + 1
) (
  input  logic [NREGS-1:0] busy,
  output logic [CW-1:0]    count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < NREGS; i++) begin
      count = count + CW'(busy[i]);
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic [NRD-1:0]           rd_en,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_ready,
  output logic [AW:0]              pend_cnt
);
  if (NRD < 1 || NRD > NRD_MAX) begin : g_bad_nrd
    $error("reg_file_sb: NRD out of range");
  end
  if (NWR < 1 || NWR > NWR_MAX) begin : g_bad_nwr
    $error("reg_file_sb: NWR out of range");
  end

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      busy_cnt;
  logic             hit;
`ifdef REG_FILE_SB_BYPASS_EN
  logic [XLEN-1:0]  hit_data;
`endif

  assign iss_ready = iss_valid & ~busy[iss_addr];

  // Issue is applied after the write clears so a same-cycle collision stays busy.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) busy_nxt[wr_addr[k]] = 1'b0;
    end
    if (iss_ready) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  popcount_busy #(.NREGS(NREGS), .CW(AW + 1)) u_popcount (
    .busy  (busy),
    .count (busy_cnt)
  );

  // Later ports overwrite earlier ones, so the highest-index port wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && wr_addr[k] != '0) regs[wr_addr[k]] <= wr_data[k];
      end
      busy     <= busy_nxt;
      pend_cnt <= busy_cnt;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    hit     = 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
    hit_data = '0;
`endif
    for (int j = 0; j < NRD; j++) begin
      hit = 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
      hit_data = '0;
`endif
      for (int k = 0; k < NWR; k++) begin
        if (!rst && wr_en[k] && wr_addr[k] == rd_addr[j]) begin
          hit = 1'b1;
`ifdef REG_FILE_SB_BYPASS_EN
          hit_data = wr_data[k];
`endif
        end
      end
      if (rd_en[j] && rd_addr[j] != '0) begin
`ifdef REG_FILE_SB_BYPASS_EN
        rd_data[j] = hit ? hit_data : regs[rd_addr[j]];
        rd_busy[j] = busy[rd_addr[j]] & ~hit;
`else
        rd_data[j] = regs[rd_addr[j]];
        rd_busy[j] = busy[rd_addr[j]] | hit;
`endif
      end
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic             clk;
  logic             rst;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       rd_en;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_busy;
  logic             iss_valid;
  logic [4:0]       iss_addr;
  logic             iss_ready;
  logic [5:0]       pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_pend;

  reg_file_sb dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .pend_cnt  (pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_busy();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Reference model: state as plain arrays, updated from the rules at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_pend = 0;
    end else begin
      bit accept;
      reg_idx_t a;
      accept = iss_valid && iss_addr != 0 && !m_busy[iss_addr];
      m_pend = count_busy();
      for (int k = 0; k < 2; k++) begin
        a = wr_addr[k];
        if (wr_en[k] && a != 0) begin
          m_regs[a] = wr_data[k];
          m_busy[a] = 1'b0;
        end
      end
      if (accept) m_busy[iss_addr] = 1'b1;
    end
  end

  // Every cycle: compare all outputs with what the model says they must be.
  always @(negedge clk) begin
    bit          hit;
    logic [31:0] hd;
    logic [31:0] exp_data;
    bit          exp_busy;
    check("iss_ready", 32'(iss_ready), 32'(iss_valid && (iss_addr == 0 || !m_busy[iss_addr])));
    check("pend_cnt", 32'(pend_cnt), 32'(m_pend));
    for (int j = 0; j < 2; j++) begin
      hit = 1'b0;
      hd  = '0;
      for (int k = 0; k < 2; k++) begin
        if (!rst && wr_en[k] && wr_addr[k] == rd_addr[j]) begin
          hit = 1'b1;
          hd  = wr_data[k];
        end
      end
      exp_data = '0;
      exp_busy = 1'b0;
      if (rd_en[j] && rd_addr[j] != 0) begin
`ifdef REG_FILE_SB_BYPASS_EN
        exp_data = hit ? hd : m_regs[rd_addr[j]];
        exp_busy = m_busy[rd_addr[j]] && !hit;
`else
        exp_data = m_regs[rd_addr[j]];
        exp_busy = m_busy[rd_addr[j]] || hit;
`endif
      end
      check($sformatf("rd_data%0d", j), rd_data[j], exp_data);
      check($sformatf("rd_busy%0d", j), 32'(rd_busy[j]), 32'(exp_busy));
    end
  end

  task automatic clear_inputs();
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_en     = '0;
    rd_addr   = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic issue(input logic [4:0] a);
    iss_valid = 1'b1;
    iss_addr  = a;
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
    wr_en[k]   = 1'b1;
    wr_addr[k] = a;
    wr_data[k] = d;
  endtask

  task automatic rd(input int j, input logic [4:0] a);
    rd_en[j]   = 1'b1;
    rd_addr[j] = a;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    rd(0, 5'd3);
    @(negedge clk);
    check("lit_reset_pend", 32'(pend_cnt), 32'd0);
    check("lit_reset_rd", rd_data[0], 32'd0);
    tick();
    rst = 1'b0;

    // Busy 3 and 7, then reset mid-run.
    tick(); issue(5'd3);
    tick(); issue(5'd7);
    tick();
    tick();
    @(negedge clk);
    check("lit_pend_two", 32'(pend_cnt), 32'd2);
    tick();
    rst = 1'b1;
    rd(0, 5'd3); rd(1, 5'd7); issue(5'd3);
    @(negedge clk);
    check("lit_rst_pend", 32'(pend_cnt), 32'd0);
    check("lit_rst_rd0", rd_data[0], 32'd0);
    check("lit_rst_busy0", 32'(rd_busy[0]), 32'd0);
    check("lit_rst_iss", 32'(iss_ready), 32'd1);
    tick();
    rst = 1'b0;
    rd(0, 5'd3);
    @(negedge clk);
    check("lit_post_rst_busy", 32'(rd_busy[0]), 32'd0);

    // Two ports collide on x5.
    tick(); wr(0, 5'd5, 32'hAAAA); wr(1, 5'd5, 32'h5555);
    tick(); rd(0, 5'd5); rd(1, 5'd5);
    @(negedge clk);
    check("lit_waw_x5", rd_data[0], 32'h5555);
    check("lit_waw_x5_p1", rd_data[1], 32'h5555);

    // Issue x9, reject a second issue, clear by write.
    tick(); issue(5'd9);
    tick(); rd(0, 5'd9); issue(5'd9);
    @(negedge clk);
    check("lit_x9_busy", 32'(rd_busy[0]), 32'd1);
    check("lit_x9_reissue", 32'(iss_ready), 32'd0);
    tick(); wr(0, 5'd9, 32'h1234);
    @(negedge clk);
    check("lit_x9_pend1", 32'(pend_cnt), 32'd1);
    tick(); rd(0, 5'd9);
    @(negedge clk);
    check("lit_x9_data", rd_data[0], 32'h1234);
    check("lit_x9_free", 32'(rd_busy[0]), 32'd0);
    tick();
    @(negedge clk);
    check("lit_x9_pend0", 32'(pend_cnt), 32'd0);

    // Issue and write x4 in the same cycle.
    tick(); issue(5'd4); wr(1, 5'd4, 32'h77);
    tick(); rd(0, 5'd4);
    @(negedge clk);
    check("lit_x4_data", rd_data[0], 32'h77);
    check("lit_x4_busy", 32'(rd_busy[0]), 32'd1);
    tick();
    @(negedge clk);
    check("lit_x4_pend", 32'(pend_cnt), 32'd1);
    tick(); wr(0, 5'd4, 32'h0);
    tick();
    tick();

    // Read x6 while it is being written.
    tick(); wr(0, 5'd6, 32'h1111);
    tick(); wr(0, 5'd6, 32'hDEAD); rd(1, 5'd6);
    @(negedge clk);
`ifdef REG_FILE_SB_BYPASS_EN
    check("lit_x6_bypass_data", rd_data[1], 32'hDEAD);
    check("lit_x6_bypass_busy", 32'(rd_busy[1]), 32'd0);
`else
    check("lit_x6_old_data", rd_data[1], 32'h1111);
    check("lit_x6_old_busy", 32'(rd_busy[1]), 32'd1);
`endif
    tick(); rd(1, 5'd6);
    @(negedge clk);
    check("lit_x6_stored", rd_data[1], 32'hDEAD);

    // Register 0 ignores writes and issues.
    tick(); wr(0, 5'd0, 32'hFFFF); issue(5'd0);
    @(negedge clk);
    check("lit_x0_iss", 32'(iss_ready), 32'd1);
    tick(); rd(0, 5'd0); rd(1, 5'd0);
    @(negedge clk);
    check("lit_x0_rd0", rd_data[0], 32'd0);
    check("lit_x0_rd1", rd_data[1], 32'd0);
    tick();
    @(negedge clk);
    check("lit_x0_pend", 32'(pend_cnt), 32'd0);

    // Random traffic, biased to a few low registers for collisions.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst       = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        wr_en[k]   = ($urandom_range(0, 2) == 0);
        wr_addr[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        wr_data[k] = $urandom;
        rd_en[k]   = ($urandom_range(0, 3) != 0);
        rd_addr[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      end
      iss_valid = ($urandom_range(0, 1) == 0);
      iss_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
